// File: rtl/scan_ctrl_pkg.sv
// Shared types and width helpers for the scan chain controller.
package scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LATCH,
    CAPTURE,
    UNLOAD,
    DONE
  } state_t;

  function automatic int slot_w(input int half);
    return (half < 1) ? 1 : $clog2(2 * half);
  endfunction

  function automatic int bit_w(input int nb);
    return (nb < 1) ? 1 : $clog2(nb + 1);
  endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Slot divider: 2*HALF cycles per slot, low phase first, with last-low/last-high strobes.
module scan_slot_timer
  import scan_ctrl_pkg::*;
#(
  parameter int HALF = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic hold_low,
  output logic phase,
  output logic last_low,
  output logic last_high
);

  localparam int SW = slot_w(HALF);
  localparam logic [SW-1:0] TOP = SW'(2 * HALF - 1);
  localparam logic [SW-1:0] MID = SW'(HALF);

  // rem counts down from TOP; rem >= MID is the low phase
  logic [SW-1:0] rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem   <= '0;
      phase <= 1'b0;
    end else if (!run || rem == '0) begin
      rem   <= TOP;
      phase <= 1'b0;
    end else begin
      rem <= rem - 1'b1;
      if (rem == MID && !hold_low) phase <= 1'b1;
    end
  end

  assign last_low  = run && (rem == MID);
  assign last_high = run && (rem == '0);

endmodule

// File: rtl/scan_chain_controller.sv
// Drives a serial scan chain: shift inputs in, latch, capture outputs, shift them back out.
// state   | meaning
// IDLE    | waiting for start
// LOAD    | NB slots shifting in_data into the chain, MSB first
// LATCH   | one slot, scan_clk low, latch_enable high
// CAPTURE | one slot with scan_select high (single capture edge)
// UNLOAD  | NB slots shifting captured bits out of the tail
// DONE    | one-cycle done pulse, out_data updated
module scan_chain_controller
  import scan_ctrl_pkg::*;
#(
  parameter int NUM_DESIGNS = 4,
  parameter int NUM_IOS     = 8,
  parameter int HALF        = 1
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_n,
  input  logic                             start,
  input  logic [NUM_DESIGNS*NUM_IOS-1:0]   in_data,
  output logic                             busy,
  output logic                             done,
  output logic [NUM_DESIGNS*NUM_IOS-1:0]   out_data,
  output logic                             scan_clk,
  output logic                             scan_data_o,
  output logic                             scan_select,
  output logic                             latch_enable,
  input  logic                             scan_data_i
);

  localparam int NB = NUM_DESIGNS * NUM_IOS;
  localparam int BW = bit_w(NB);
  localparam logic [BW-1:0] LAST_BIT = BW'(NB - 1);

  logic [1:0]    rst_q;
  logic          rst_n;
  state_t        state;
  logic [BW-1:0] bit_cnt;
  logic [NB-1:0] sh;
  logic [NB-1:0] cap;
  logic          run;
  logic          hold_low;
  logic          last_low;
  logic          last_high;

  // assert immediately, release only on a clock edge
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) rst_q <= 2'b00;
    else           rst_q <= {rst_q[0], 1'b1};
  end
  assign rst_n = rst_q[1];

  assign run      = state inside {LOAD, LATCH, CAPTURE, UNLOAD};
  assign hold_low = (state == LATCH);

  scan_slot_timer #(.HALF(HALF)) u_timer (
    .clk       (wb_clk_i),
    .rst_n     (rst_n),
    .run       (run),
    .hold_low  (hold_low),
    .phase     (scan_clk),
    .last_low  (last_low),
    .last_high (last_high)
  );

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      sh           <= '0;
      cap          <= '0;
      out_data     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      scan_data_o  <= 1'b0;
      scan_select  <= 1'b0;
      latch_enable <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= LOAD;
            busy        <= 1'b1;
            bit_cnt     <= LAST_BIT;
            scan_data_o <= in_data[NB-1];
            sh          <= in_data << 1;
          end
        end
        LOAD: begin
          if (last_high) begin
            if (bit_cnt == '0) begin
              state        <= LATCH;
              latch_enable <= 1'b1;
              scan_data_o  <= 1'b0;
            end else begin
              bit_cnt     <= bit_cnt - 1'b1;
              scan_data_o <= sh[NB-1];
              sh          <= sh << 1;
            end
          end
        end
        LATCH: begin
          if (last_high) begin
            state        <= CAPTURE;
            latch_enable <= 1'b0;
            scan_select  <= 1'b1;
          end
        end
        CAPTURE: begin
          if (last_high) begin
            state       <= UNLOAD;
            scan_select <= 1'b0;
            bit_cnt     <= LAST_BIT;
          end
        end
        UNLOAD: begin
          // first bit out lands in the MSB after NB shifts
          if (last_low) cap <= {cap[NB-2:0], scan_data_i};
          if (last_high) begin
            if (bit_cnt == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              out_data <= cap;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_controller.sv
// Bench for scan_chain_controller: behavioural 4x8 scan chain, vector table, random loop, corner sequences.
`timescale 1ns/1ps
module tb_scan_chain_controller;

  localparam int ND = 4;
  localparam int NI = 8;
  localparam int NB = ND * NI;
  localparam int LAT1 = (2 * NB + 2) * 2 * 1 + 1;
  localparam int LAT3 = (2 * NB + 2) * 2 * 3 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nmis = 0;

  // ---------------- HALF=1 instance ----------------
  logic          start1, busy1, done1, sclk1, sdo1, ssel1, le1, sdi1, inv1;
  logic [NB-1:0] in1, out1, ch1, din1;

  scan_chain_controller #(.NUM_DESIGNS(ND), .NUM_IOS(NI), .HALF(1)) dut1 (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .start(start1), .in_data(in1),
    .busy(busy1), .done(done1), .out_data(out1), .scan_clk(sclk1),
    .scan_data_o(sdo1), .scan_select(ssel1), .latch_enable(le1), .scan_data_i(sdi1)
  );

  always @(posedge sclk1) begin
    if (ssel1) ch1 <= inv1 ? ~din1 : din1;
    else       ch1 <= {ch1[NB-2:0], sdo1};
  end
  always @(posedge clk) if (le1) din1 <= ch1;
  assign sdi1 = ch1[NB-1];

  // ---------------- HALF=3 instance ----------------
  logic          start3, busy3, done3, sclk3, sdo3, ssel3, le3, sdi3, inv3;
  logic [NB-1:0] in3, out3, ch3, din3;

  scan_chain_controller #(.NUM_DESIGNS(ND), .NUM_IOS(NI), .HALF(3)) dut3 (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .start(start3), .in_data(in3),
    .busy(busy3), .done(done3), .out_data(out3), .scan_clk(sclk3),
    .scan_data_o(sdo3), .scan_select(ssel3), .latch_enable(le3), .scan_data_i(sdi3)
  );

  always @(posedge sclk3) begin
    if (ssel3) ch3 <= inv3 ? ~din3 : din3;
    else       ch3 <= {ch3[NB-2:0], sdo3};
  end
  always @(posedge clk) if (le3) din3 <= ch3;
  assign sdi3 = ch3[NB-1];

  // ---------------- observers ----------------
  int   acc1 = 0, first_hi1 = -1, sdo_bad1 = 0;
  logic prev_sdo1 = 1'b0, prev_busy1 = 1'b0;
  always @(negedge clk) begin
    if (busy1 && !prev_busy1) begin
      acc1      <= cyc;
      first_hi1 <= sdo1 ? 0 : -1;
      sdo_bad1  <= 0;
    end else if (busy1) begin
      if ((cyc - acc1) < 2 * NB && sdo1 && first_hi1 < 0) first_hi1 <= (cyc - acc1) / 2;
      if (sdo1 !== prev_sdo1 && ((cyc - acc1) % 2) != 0) sdo_bad1 <= sdo_bad1 + 1;
    end
    prev_sdo1  <= sdo1;
    prev_busy1 <= busy1;
  end

  int   rises3 = 0, sel_rise3 = 0, le_cnt3 = 0, le_bad3 = 0, r0 = -1, r1 = -1;
  logic prev_sclk3 = 1'b0, prev_busy3 = 1'b0;
  always @(negedge clk) begin
    if (busy3 && !prev_busy3) begin
      rises3 <= 0; sel_rise3 <= 0; le_cnt3 <= 0; le_bad3 <= 0; r0 <= -1; r1 <= -1;
    end else if (busy3) begin
      if (sclk3 && !prev_sclk3) begin
        rises3 <= rises3 + 1;
        if (ssel3) sel_rise3 <= sel_rise3 + 1;
        if (rises3 == 0) r0 <= cyc;
        if (rises3 == 1) r1 <= cyc;
      end
      if (le3) begin
        le_cnt3 <= le_cnt3 + 1;
        if (sclk3) le_bad3 <= le_bad3 + 1;
      end
    end
    prev_sclk3 <= sclk3;
    prev_busy3 <= busy3;
  end

  // ---------------- reference model and helpers ----------------
  function automatic logic [NB-1:0] model_out(input logic [NB-1:0] d, input logic inv);
    return inv ? ~d : d;
  endfunction

  // bit i of in_data is presented in LOAD slot NB-1-i
  function automatic int model_first_hi(input logic [NB-1:0] d);
    for (int i = NB - 1; i >= 0; i--) if (d[i]) return NB - 1 - i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic txn1(input logic [NB-1:0] d, input logic inv, output int lat);
    int a;
    @(negedge clk);
    in1 = d; inv1 = inv; start1 = 1'b1; a = cyc + 1;
    @(negedge clk);
    start1 = 1'b0;
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      if (done1) begin lat = cyc - a + 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic txn3(input logic [NB-1:0] d, input logic inv, output int lat);
    int a;
    @(negedge clk);
    in3 = d; inv3 = inv; start3 = 1'b1; a = cyc + 1;
    @(negedge clk);
    start3 = 1'b0;
    lat = -1;
    for (int i = 0; i < 1000; i++) begin
      if (done3) begin lat = cyc - a + 1; break; end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [NB-1:0] d;
    logic          inv;
    logic [NB-1:0] exp;
    int            first_slot;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int            lat, a, k, nd, dc[3];
    logic [NB-1:0] d;
    logic          inv;

    tbl[0] = '{32'hA5C30F96, 1'b0, 32'hA5C30F96, 0};
    tbl[1] = '{32'h00000001, 1'b1, 32'hFFFFFFFE, 31};
    tbl[2] = '{32'h00000000, 1'b0, 32'h00000000, -1};
    tbl[3] = '{32'hFFFFFFFF, 1'b1, 32'h00000000, 0};
    tbl[4] = '{32'h80000000, 1'b0, 32'h80000000, 0};
    tbl[5] = '{32'h0000FF00, 1'b1, 32'hFFFF00FF, 16};
    tbl[6] = '{32'h12345678, 1'b0, 32'h12345678, 3};

    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0;
    in1 = '0; in3 = '0; inv1 = 1'b0; inv3 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs h1", {busy1, done1, sclk1, sdo1, ssel1, le1, out1}, '0);
    check("reset outputs h3", {busy3, done3, sclk3, sdo3, ssel3, le3, out3}, '0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      txn1(tbl[i].d, tbl[i].inv, lat);
      check($sformatf("vec%0d out_data", i), out1, tbl[i].exp);
      check($sformatf("vec%0d latency", i), lat, LAT1);
      check($sformatf("vec%0d first high slot", i), first_hi1, tbl[i].first_slot);
      check($sformatf("vec%0d data change off slot start", i), sdo_bad1, 0);
    end

    for (int i = 0; i < 16; i++) begin
      d   = $urandom;
      inv = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      txn1(d, inv, lat);
      check($sformatf("rand%0d out_data", i), out1, model_out(d, inv));
      check($sformatf("rand%0d latency", i), lat, LAT1);
      check($sformatf("rand%0d first high slot", i), first_hi1, model_first_hi(d));
    end

    // start pulse during LOAD with different in_data must be ignored
    d = 32'h3C5A96E1;
    @(negedge clk);
    in1 = d; inv1 = 1'b1; start1 = 1'b1; a = cyc + 1;
    @(negedge clk);
    start1 = 1'b0; in1 = ~d;
    repeat (9) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    nd = 0; lat = -1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (done1) begin
        nd++;
        if (lat < 0) begin
          lat = cyc - a + 1;
          check("ignored start out_data", out1, model_out(d, 1'b1));
        end
      end
    end
    check("ignored start done count", nd, 1);
    check("ignored start latency", lat, LAT1);
    check("ignored start out_data held", out1, model_out(d, 1'b1));

    // reset in UNLOAD slot 10
    @(negedge clk);
    in1 = 32'hDEADBEEF; inv1 = 1'b0; start1 = 1'b1; a = cyc + 1;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 200 && cyc < a + (NB + 2) * 2 + 20; i++) @(negedge clk);
    check("busy before reset", busy1, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid-unload reset outputs", {busy1, done1, sclk1, sdo1, ssel1, le1, out1}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    txn1(32'h0F1E2D3C, 1'b1, lat);
    check("post reset out_data", out1, model_out(32'h0F1E2D3C, 1'b1));
    check("post reset latency", lat, LAT1);

    // start held high: three back-to-back transactions
    d = 32'hC001D00D;
    dc[0] = 0; dc[1] = 0; dc[2] = 0;
    @(negedge clk);
    in1 = d; inv1 = 1'b0; start1 = 1'b1; a = cyc + 1; k = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done1) begin
        dc[k] = cyc;
        k++;
        if (k == 3) begin start1 = 1'b0; break; end
      end
    end
    start1 = 1'b0;
    check("held start done count", k, 3);
    check("held start first latency", dc[0] - a + 1, LAT1);
    check("held start spacing 1-2", dc[1] - dc[0], LAT1 + 1);
    check("held start spacing 2-3", dc[2] - dc[1], LAT1 + 1);
    check("held start out_data", out1, d);
    nd = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done1) nd++;
    end
    check("held start no extra done", nd, 0);
    check("held start idle after", busy1, 1'b0);

    // slower slots
    txn3(32'hA5C30F96, 1'b0, lat);
    check("half3 out_data", out3, 32'hA5C30F96);
    check("half3 latency", lat, LAT3);
    check("half3 scan_clk period", r1 - r0, 6);
    check("half3 rising edges", rises3, 2 * NB + 1);
    check("half3 latch cycles", le_cnt3, 6);
    check("half3 latch with clk high", le_bad3, 0);
    check("half3 capture edges", sel_rise3, 1);
    txn3(32'h00000001, 1'b1, lat);
    check("half3 inverted out_data", out3, 32'hFFFFFFFE);
    check("half3 inverted latency", lat, LAT3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
